// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single strobe/acknowledge IO bus.
// Optional acknowledge timeout is compiled in with `define IO_ARB_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no bus cycle; pick a requester and launch its transfer
// WAIT_ACK | io_bus_enable high, waiting for io_acknowledge (or timeout)
// DONE     | bus released; one-cycle done pulse to the granted requester
module io_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic        m0_rw,
    input  logic [1:0]  m0_byte_enable,
    input  logic [15:0] m0_wdata,
    output logic        m0_done,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic        m1_rw,
    input  logic [1:0]  m1_byte_enable,
    input  logic [15:0] m1_wdata,
    output logic        m1_done,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic [15:0] io_address,
    output logic        io_bus_enable,
    output logic [1:0]  io_byte_enable,
    output logic        io_rw,
    output logic [15:0] io_write_data,
    input  logic [15:0] io_read_data,
    input  logic        io_acknowledge
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

    state_t state, state_next;
    logic   grant_m1;
    logic   prio_m1;
    logic   launch;
    logic   pick_m1;
    logic   ack_hit;
    logic   timeout_hit;
    logic   finish;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("io_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    assign launch  = (state == IDLE) && (m0_req || m1_req);
    // m1 wins only when alone or when it holds the round-robin priority
    assign pick_m1 = m1_req && (!m0_req || prio_m1);
    assign ack_hit = (state == WAIT_ACK) && io_acknowledge;
    assign finish  = ack_hit || timeout_hit;

`ifdef IO_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timer;
    logic       m0_err_q;
    logic       m1_err_q;

    assign timeout_hit = (state == WAIT_ACK) && !io_acknowledge && (timer == 8'd0);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            timer <= 8'd0;
        end else if (launch) begin
            timer <= TIMER_LOAD;
        end else if (state == WAIT_ACK && timer != 8'd0) begin
            timer <= timer - 8'd1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else if (finish) begin
            if (grant_m1) m1_err_q <= timeout_hit;
            else          m0_err_q <= timeout_hit;
        end
    end

    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    assign timeout_hit = 1'b0;
    assign m0_err      = 1'b0;
    assign m1_err      = 1'b0;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (m0_req || m1_req) state_next = WAIT_ACK;
            WAIT_ACK: if (finish)           state_next = DONE;
            DONE:                           state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        m0_done = 1'b0;
        m1_done = 1'b0;
        if (state == DONE) begin
            m0_done = !grant_m1;
            m1_done = grant_m1;
        end
    end

    // Bus fields are loaded only at launch, so they cannot move while strobed
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            grant_m1       <= 1'b0;
            prio_m1        <= 1'b0;
            io_bus_enable  <= 1'b0;
            io_address     <= 16'h0000;
            io_rw          <= 1'b0;
            io_byte_enable <= 2'b00;
            io_write_data  <= 16'h0000;
            m0_rdata       <= 16'h0000;
            m1_rdata       <= 16'h0000;
        end else if (launch) begin
            grant_m1       <= pick_m1;
            prio_m1        <= !pick_m1;
            io_bus_enable  <= 1'b1;
            io_address     <= pick_m1 ? m1_addr        : m0_addr;
            io_rw          <= pick_m1 ? m1_rw          : m0_rw;
            io_byte_enable <= pick_m1 ? m1_byte_enable : m0_byte_enable;
            io_write_data  <= pick_m1 ? m1_wdata       : m0_wdata;
        end else if (finish) begin
            io_bus_enable <= 1'b0;
            if (timeout_hit) begin
                if (grant_m1) m1_rdata <= 16'h0000;
                else          m0_rdata <= 16'h0000;
            end else if (io_rw) begin
                if (grant_m1) m1_rdata <= io_read_data;
                else          m0_rdata <= io_read_data;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized bench for io_bus_arbiter: the bench plays both requesters and the
// IO slave, predicting grant order, bus fields, rdata and err from a simple model.
module tb_io_bus_arbiter;

`ifdef IO_ARB_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b1;
    localparam int DLY_MAX = 12;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
    localparam int DLY_MAX = 6;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        m0_req, m1_req;
    logic [15:0] m0_addr, m1_addr;
    logic        m0_rw, m1_rw;
    logic [1:0]  m0_byte_enable, m1_byte_enable;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_done, m1_done;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_err, m1_err;
    logic [15:0] io_address;
    logic        io_bus_enable;
    logic [1:0]  io_byte_enable;
    logic        io_rw;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;

    io_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw),
        .m0_byte_enable(m0_byte_enable), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw),
        .m1_byte_enable(m1_byte_enable), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .io_address(io_address), .io_bus_enable(io_bus_enable),
        .io_byte_enable(io_byte_enable), .io_rw(io_rw),
        .io_write_data(io_write_data), .io_read_data(io_read_data),
        .io_acknowledge(io_acknowledge)
    );

    always #5 clk_clk = ~clk_clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model state
    logic [15:0] a_addr [2];
    logic        a_rw   [2];
    logic [1:0]  a_be   [2];
    logic [15:0] a_wd   [2];
    logic [15:0] exp_rdata [2];
    logic        exp_err   [2];
    int          last_granted;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v);
        if (i == 0) begin
            m0_addr = a_addr[0]; m0_rw = a_rw[0]; m0_byte_enable = a_be[0]; m0_wdata = a_wd[0];
            m0_req = v;
        end else begin
            m1_addr = a_addr[1]; m1_rw = a_rw[1]; m1_byte_enable = a_be[1]; m1_wdata = a_wd[1];
            m1_req = v;
        end
    endtask

    task automatic rand_attr(input int i);
        a_addr[i] = 16'($urandom);
        a_rw[i]   = 1'($urandom);
        a_be[i]   = 2'($urandom);
        a_wd[i]   = 16'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_m0_rdata"}, 36'(m0_rdata), 36'(exp_rdata[0]));
        check({tag, "_m1_rdata"}, 36'(m1_rdata), 36'(exp_rdata[1]));
        check({tag, "_m0_err"},   36'(m0_err),   36'(exp_err[0]));
        check({tag, "_m1_err"},   36'(m1_err),   36'(exp_err[1]));
    endtask

    // Plays the IO slave for requester i's transfer; dly = cycles before ack.
    task automatic serve(input int i, input int dly, input logic [15:0] rd,
                         input bit drop_early, input bit poke_other);
        int waited;
        int n;
        bit to;
        logic [35:0] fields;
        waited = 0;
        while (!io_bus_enable && waited < 4) begin
            @(negedge clk_clk);
            waited++;
        end
        check("grant_latency", 36'(waited), 36'd1);
        fields = {a_addr[i], a_rw[i], a_be[i], a_wd[i], 1'b1};
        check("bus_fields", {io_address, io_rw, io_byte_enable, io_write_data, io_bus_enable}, fields);
        if (drop_early) set_req(i, 1'b0);
        to = TMO_EN && (dly >= TMO);
        n  = to ? TMO - 1 : dly;
        for (int k = 0; k < n; k++) begin
            if (poke_other && k == 0) set_req(1 - i, 1'b1);
            if (poke_other && k == 1) set_req(1 - i, 1'b0);
            io_read_data = 16'($urandom);
            @(negedge clk_clk);
            check("bus_hold", {io_address, io_rw, io_byte_enable, io_write_data, io_bus_enable}, fields);
            check("no_early_done", 36'({m0_done, m1_done}), 36'd0);
        end
        if (!to) begin
            io_read_data   = rd;
            io_acknowledge = 1'b1;
        end
        @(negedge clk_clk);
        io_acknowledge = 1'b0;
        io_read_data   = 16'($urandom);
        if (to) begin
            exp_rdata[i] = 16'h0000;
            exp_err[i]   = 1'b1;
        end else begin
            if (a_rw[i]) exp_rdata[i] = rd;
            exp_err[i] = 1'b0;
        end
        check("done_pulse", 36'({m1_done, m0_done}), (i == 0) ? 36'd1 : 36'd2);
        check("bus_released", 36'(io_bus_enable), 36'd0);
        check_outputs("done");
        set_req(i, 1'b0);
        @(negedge clk_clk);
        check("done_one_cycle", 36'({m1_done, m0_done}), 36'd0);
        check("gap_low", 36'(io_bus_enable), 36'd0);
        check_outputs("hold");
        last_granted = i;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
        exp_err[0] = 1'b0;    exp_err[1] = 1'b0;
        last_granted = 1;
    endtask

    initial begin
        int pat, w, d;
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m1_addr = 0; m0_rw = 0; m1_rw = 0;
        m0_byte_enable = 0; m1_byte_enable = 0; m0_wdata = 0; m1_wdata = 0;
        io_read_data = 0; io_acknowledge = 0;
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = 0; a_rw[i] = 0; a_be[i] = 0; a_wd[i] = 0;
        end
        reset_reset = 1'b1;
        #1;
        check("reset_bus", {io_address, io_rw, io_byte_enable, io_write_data, io_bus_enable}, 36'd0);
        check("reset_done", 36'({m0_done, m1_done}), 36'd0);
        @(negedge clk_clk);
        do_reset();
        check_outputs("reset");

        // m0 read with ack after 3 cycles
        a_addr[0] = 16'h0040; a_rw[0] = 1'b1; a_be[0] = 2'b11; a_wd[0] = 16'h0;
        set_req(0, 1'b1);
        serve(0, 3, 16'hBEEF, 1'b0, 1'b0);

        // m1 write held until ack
        a_addr[1] = 16'h0002; a_rw[1] = 1'b0; a_be[1] = 2'b01; a_wd[1] = 16'h1234;
        set_req(1, 1'b1);
        serve(1, 4, 16'hDEAD, 1'b0, 1'b0);

        // simultaneous writes: m1 was granted last, so m0 goes first
        rand_attr(0); rand_attr(1); a_rw[0] = 1'b0; a_rw[1] = 1'b0;
        set_req(0, 1'b1); set_req(1, 1'b1);
        serve(0, 1, 16'h1111, 1'b0, 1'b0);
        serve(1, 0, 16'h2222, 1'b0, 1'b0);

        // m1 request withdrawn before it could be granted is never serviced
        rand_attr(0); rand_attr(1);
        set_req(0, 1'b1);
        serve(0, 3, 16'h3333, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_clk);
            check("withdrawn_idle", 36'({io_bus_enable, m0_done, m1_done}), 36'd0);
        end

        // acknowledge while idle has no effect
        io_acknowledge = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_clk);
            check("stray_ack", 36'({io_bus_enable, m0_done, m1_done}), 36'd0);
        end
        io_acknowledge = 1'b0;
        @(negedge clk_clk);

        if (TMO_EN) begin
            rand_attr(0); a_rw[0] = 1'b1;
            set_req(0, 1'b1);
            serve(0, TMO, 16'h5555, 1'b0, 1'b0);
        end

        for (int e = 0; e < 40; e++) begin
            pat = $urandom_range(1, 3);
            rand_attr(0); rand_attr(1);
            if (pat[0]) set_req(0, 1'b1);
            if (pat[1]) set_req(1, 1'b1);
            if (pat == 3) w = (last_granted == 1) ? 0 : 1;
            else          w = pat[1] ? 1 : 0;
            d = $urandom_range(0, DLY_MAX);
            serve(w, d, 16'($urandom), 1'($urandom), 1'b0);
            if (pat == 3) begin
                d = $urandom_range(0, DLY_MAX);
                serve(1 - w, d, 16'($urandom), 1'($urandom), 1'b0);
            end
        end

        // reset in the middle of a transfer aborts it without a done pulse
        rand_attr(0); rand_attr(1); a_rw[0] = 1'b1;
        set_req(0, 1'b1);
        @(negedge clk_clk);
        check("pre_reset_en", 36'(io_bus_enable), 36'd1);
        #2 reset_reset = 1'b1;
        #1;
        check("async_reset_bus", {io_address, io_rw, io_byte_enable, io_write_data, io_bus_enable}, 36'd0);
        check("async_reset_done", 36'({m0_done, m1_done}), 36'd0);
        set_req(0, 1'b0);
        @(negedge clk_clk);
        do_reset();
        check_outputs("post_reset");
        rand_attr(0); rand_attr(1);
        set_req(0, 1'b1); set_req(1, 1'b1);
        serve(0, 2, 16'h7777, 1'b0, 1'b0);
        serve(1, 1, 16'h8888, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
